// File: rtl/tmul_pkg.sv
// Shared types and lane decode for the tile-multiply operand extractor.
// Decoding is a pure function so every lane instantiates identical logic.
package tmul_pkg;

    localparam int LANES  = 16;
    localparam int ELEM_W = 16;
    localparam int MANT_W = 11;
    localparam int EXP_W  = 8;
    localparam int DIGITS = 4;

    typedef enum logic [1:0] {
        MODE_FP16 = 2'b00,
        MODE_BF16 = 2'b01,
        MODE_INT8 = 2'b10
    } mode_e;

    typedef struct packed {
        logic       neg;
        logic [2:0] mag;
    } booth_digit_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              zero;
        logic              inf;
        logic              nan;
    } lane_dec_t;

    // Subnormals report exponent 1 so the hidden-bit-free mantissa aligns like a normal.
    // The reserved mode code falls through to FP16.
    function automatic lane_dec_t decode_lane(input logic [1:0] mode, input logic [ELEM_W-1:0] e);
        lane_dec_t  d;
        logic [7:0] mag;
        d   = '0;
        mag = '0;
        case (mode)
            MODE_BF16: begin
                d.sign = e[15];
                d.exp  = (e[14:7] == 8'd0) ? 8'd1 : e[14:7];
                d.mant = {(e[14:7] != 8'd0), e[6:0], 3'b000};
                d.zero = (e[14:7] == 8'd0)   && (e[6:0] == 7'd0);
                d.inf  = (e[14:7] == 8'hFF)  && (e[6:0] == 7'd0);
                d.nan  = (e[14:7] == 8'hFF)  && (e[6:0] != 7'd0);
            end
            MODE_INT8: begin
                mag    = e[7] ? (8'd0 - e[7:0]) : e[7:0];
                d.sign = e[7];
                d.exp  = '0;
                d.mant = {3'b000, mag};
                d.zero = (e[7:0] == 8'd0);
            end
            default: begin
                d.sign = e[15];
                d.exp  = (e[14:10] == 5'd0) ? 8'd1 : {3'b000, e[14:10]};
                d.mant = {(e[14:10] != 5'd0), e[9:0]};
                d.zero = (e[14:10] == 5'd0)  && (e[9:0] == 10'd0);
                d.inf  = (e[14:10] == 5'h1F) && (e[9:0] == 10'd0);
                d.nan  = (e[14:10] == 5'h1F) && (e[9:0] != 10'd0);
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r8_encoder.sv
// Radix-8 Booth recoder: an 11-bit unsigned mantissa becomes four signed
// digits in -4..+4, sign-magnitude, with zero always encoded as 0000.
module booth_r8_encoder
    import tmul_pkg::*;
(
    input  logic [MANT_W-1:0]             mant_i,
    output booth_digit_t [DIGITS-1:0]     digit_o
);

    logic [3*DIGITS:0] ext;

    // Overlapping 4-bit windows {m[3k+2], m[3k+1], m[3k], m[3k-1]}; the top bit is the implicit zero.
    assign ext = {1'b0, mant_i, 1'b0};

    function automatic booth_digit_t encode_group(input logic [3:0] g);
        booth_digit_t d;
        case (g)
            4'b0000: d = 4'b0000;
            4'b0001: d = 4'b0001;
            4'b0010: d = 4'b0001;
            4'b0011: d = 4'b0010;
            4'b0100: d = 4'b0010;
            4'b0101: d = 4'b0011;
            4'b0110: d = 4'b0011;
            4'b0111: d = 4'b0100;
            4'b1000: d = 4'b1100;
            4'b1001: d = 4'b1011;
            4'b1010: d = 4'b1011;
            4'b1011: d = 4'b1010;
            4'b1100: d = 4'b1010;
            4'b1101: d = 4'b1001;
            4'b1110: d = 4'b1001;
            default: d = 4'b0000;
        endcase
        return d;
    endfunction

    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            digit_o[k] = encode_group(ext[3*k +: 4]);
        end
    end

endmodule

// File: rtl/tmul_operand_extractor.sv
// Two-stage operand unpack and Booth-encode pipeline for one 16-lane B row per beat.
// S1 holds decoded lane fields; S2 adds Booth digits and drives the outputs.
module tmul_operand_extractor
    import tmul_pkg::*;
(
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [1:0]                            in_mode_i,
    input  logic [LANES-1:0][ELEM_W-1:0]          in_row_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [1:0]                            out_mode_o,
    output logic [LANES-1:0]                      out_sign_o,
    output logic [LANES-1:0][EXP_W-1:0]           out_exp_o,
    output logic [LANES-1:0][MANT_W-1:0]          out_mant_o,
    output logic [LANES-1:0][DIGITS-1:0][3:0]     out_digit_o,
    output logic [LANES-1:0]                      out_zero_o,
    output logic [LANES-1:0]                      out_inf_o,
    output logic [LANES-1:0]                      out_nan_o
);

    logic                                s1_valid_q, s1_valid_d;
    logic [1:0]                          s1_mode_q;
    lane_dec_t [LANES-1:0]               s1_dec_q, s1_dec_d;
    logic                                s2_valid_q, s2_valid_d;
    logic [1:0]                          s2_mode_q;
    lane_dec_t [LANES-1:0]               s2_dec_q;
    booth_digit_t [LANES-1:0][DIGITS-1:0] s2_digit_q, s1_digit;
    logic                                s2_adv;
    logic                                accept;
    logic                                s2_load;

    assign s2_adv     = ~s2_valid_q | out_ready_i;
    assign in_ready_o = ~s1_valid_q | s2_adv;
    assign accept     = in_valid_i & in_ready_o & ~flush_i;
    assign s2_load    = s2_adv & s1_valid_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_dec_d[i] = decode_lane(in_mode_i, in_row_i[i]);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_booth
        booth_r8_encoder u_booth (
            .mant_i  (s1_dec_q[g].mant),
            .digit_o (s1_digit[g])
        );
    end

    // A row leaves S1 whenever S2 can take it; flush empties both stages regardless.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_d = s1_valid_q;
            end
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (s2_adv) begin
                s1_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= '0;
            s1_dec_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= '0;
            s2_dec_q   <= '0;
            s2_digit_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) begin
                s1_mode_q <= in_mode_i;
                s1_dec_q  <= s1_dec_d;
            end
            if (s2_load) begin
                s2_mode_q  <= s1_mode_q;
                s2_dec_q   <= s1_dec_q;
                s2_digit_q <= s1_digit;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            out_sign_o[i] = s2_dec_q[i].sign;
            out_exp_o[i]  = s2_dec_q[i].exp;
            out_mant_o[i] = s2_dec_q[i].mant;
            out_zero_o[i] = s2_dec_q[i].zero;
            out_inf_o[i]  = s2_dec_q[i].inf;
            out_nan_o[i]  = s2_dec_q[i].nan;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_mode_o  = s2_mode_q;
    assign out_digit_o = s2_digit_q;

endmodule

// File: doc/tmul_operand_extractor.md
# tmul_operand_extractor

Upstream operand stage of the FP16/BF16/INT8 tile-multiply datapath. It accepts one 16-lane row of packed B-operand elements per beat and unpacks each lane into sign, effective exponent, 11-bit mantissa (hidden bit included) and special-value flags. It also radix-8 Booth-encodes each mantissa into four select digits. The row-level partial-product multiplexers consume the registered outputs directly.

## Interface
- LANES, 16, elements per row; fixed at 16 because one Booth encoder is shared by 16 FMAs
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- flush  in  1  synchronous; clears both pipeline valids
- in_valid  in  1  row beat offered
- in_ready  out  1  row beat accepted when in_valid & in_ready
- in_mode  in  2  00 FP16, 01 BF16, 10 INT8, 11 reserved (treated as FP16)
- in_row  in  16×16  packed elements, lane i = in_row[i]
- out_valid  out  1  row result valid
- out_ready  in  1  consumer accepts
- out_mode  out  2  mode travelling with the row
- out_sign  out  16  per-lane sign
- out_exp  out  16×8  biased effective exponent
- out_mant  out  16×11  mantissa, hidden bit at [10]
- out_digit  out  16×4×4  Booth digits per lane; digit = {neg, mag[2:0]}
- out_zero, out_inf, out_nan  out  16 each  per-lane flags

## Operation
- FP16:
  - sign = e[15]
  - exp = {3'b0, e[14:10]}, forced to 1 when the field is 0 (subnormal)
  - mant = {field!=0, e[9:0]}
  - zero = field==0 & frac==0; inf/nan = field==31 & frac==0 / !=0
- BF16:
  - sign = e[15]
  - exp = e[14:7], forced to 1 when 0
  - mant = {field!=0, e[6:0], 3'b000}
  - zero/inf/nan as FP16 with field==255
- INT8 (low byte only; e[15:8] ignored):
  - sign = e[7]
  - mant = {3'b0, |e[7:0]|}; −128 gives 0x080
  - exp = 0; zero = byte==0; inf = nan = 0
- Booth radix-8:
  - m = {1'b0, mant}, with m[−1] = 0
  - digit k (k = 0..3) = −4·m[3k+2] + 2·m[3k+1] + m[3k] + m[3k−1]
  - range −4..+4, sign-magnitude encoding; value 0 always encodes as 0000 (never 1000)
  - Σ digit_k·8^k == mant for every lane

## Timing
- Two-stage pipeline:
  - S1 registers the decode fields and mode.
  - S2 registers the Booth digits plus S1 fields; S2 is the output.
- Latency: 2 cycles from accept to out_valid. Throughput: 1 row per cycle.
- Handshake:
  - s2_adv = ~out_valid | out_ready
  - in_ready = ~s1_valid | s2_adv (combinational from out_ready, permitted)
- Ordering and stability:
  - Rows leave in acceptance order.
  - While out_valid & ~out_ready, all out_* are held stable.
  - Maximum 2 rows in flight. With output stalled and S1 full, in_ready = 0.
- Simultaneous accept, advance and drain in one cycle: all three happen, no bubble.
- flush:
  - Clears s1_valid and out_valid next edge.
  - A beat presented in the flush cycle is dropped.
  - flush wins over in_valid.
- Reset: asynchronous clear; all outputs are 0 during and after reset (out_valid 0, data 0, in_ready 1 after deassert). Reset mid-stream discards in-flight rows.
- Data registers of invalid stages may hold stale values except after reset.

## Structure
- tmul_pkg holds:
  - mode enum (FP16, BF16, INT8)
  - LANES, MANT_W = 11, EXP_W = 8, DIGITS = 4
  - booth_digit_t {neg, mag[2:0]}
  - lane_dec_t struct {sign, exp, mant, zero, inf, nan}
- One sub-module, booth_r8_encoder: combinational, 11-bit mant in, 4 digits out; instanced per lane between S1 and S2.
- Lane decode is a function in the package.

## Test plan
- FP16 0x3C00 all lanes → sign 0, exp 0x0F, mant 0x400, digits {3..0} = 0010, 0000, 0000, 0000, latency exactly 2.
- FP16 0x0001, 0x7C00, 0x7E00 → 0x0001: exp 1, mant 0x001, digit0 0001. 0x7C00: inf=1. 0x7E00: nan=1. 0x0000: zero=1, digits all 0000.
- BF16 0xBF80 → sign 1, exp 0x7F, mant 0x400. INT8 0x0080 → sign 1, mant 0x080, digit2 0010, others 0000.
- FP16 mant 0x7FF (0x3FFF) → digit0 1001, digit1 0000, digit2 0000, digit3 0100; a random sweep checks Σ digit·8^k == mant.
- Backpressure:
  - out_ready = 0 for 4 cycles while streaming rows A, B, C: A is held stable on the output, in_ready drops once A and B fill the pipeline, and C waits.
  - Release: A, B, C emerge in order on consecutive cycles.
- Assert rst_n low with 2 rows in flight → out_valid 0 immediately. Separately, flush with in_valid high → no row emitted, and the next beat emerges 2 cycles after acceptance.
